// File: rtl/s_shift_acc_pkg.sv
// Shared types and constants for the s_shift_acc bit-serial shift-and-accumulate stage.
// The optional fused-ReLU output is enabled by defining S_SHIFT_ACC_RELU_EN.
package s_shift_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PSUM_W_DEF  = 24;
    localparam int IN_BITS_DEF = 8;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/s_shift_acc_if.sv
// Partial-sum input channel, result output channel and frame control for s_shift_acc.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface s_shift_acc_if #(
    parameter int PSUM_W = 24,
    parameter int OUT_W  = 32
);
    logic              clear;
    logic              in_signed;
    logic [PSUM_W-1:0] psum;
    logic              psum_valid;
    logic              psum_ready;
    logic [OUT_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output clear, in_signed, psum, psum_valid, out_ready,
        input  psum_ready, acc_out, out_valid, busy
    );

    modport slave (
        input  clear, in_signed, psum, psum_valid, out_ready,
        output psum_ready, acc_out, out_valid, busy
    );
endinterface

// File: rtl/s_acc_add.sv
// Combinational shift-and-add step of the accumulator: sum = (acc << 1) + ext.
// Kept as its own module so the adder can later be swapped for a CLA implementation.
module s_acc_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] ext_i,
    output logic [W-1:0] sum_o
);
    assign sum_o = (acc_i << 1) + ext_i;
endmodule

// File: rtl/s_shift_acc.sv
// Bit-serial shift-and-accumulate of signed partial sums, MSB bit-plane first, with a
// valid/ready result port. Define S_SHIFT_ACC_RELU_EN to clamp negative results to 0.
module s_shift_acc
    import s_shift_acc_pkg::*;
#(
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int IN_BITS = IN_BITS_DEF,
    parameter int OUT_W   = PSUM_W + IN_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    s_shift_acc_if.slave     bus,
    output state_t           state_o
);
    localparam int CNT_W = clog2(IN_BITS);
    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(IN_BITS - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_out_q;
    logic             out_valid_q;

    logic [OUT_W-1:0] psum_ext;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] acc_op;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] result;
    logic             accept;

    assign accept   = bus.psum_valid && bus.psum_ready;
    assign psum_ext = {{(OUT_W - PSUM_W){bus.psum[PSUM_W-1]}}, bus.psum};

    // Plane 0 starts from zero; for signed activations its weight is -2^(IN_BITS-1).
    always_comb begin
        ext    = psum_ext;
        acc_op = acc_q;
        if (state_q == IDLE) begin
            acc_op = '0;
            if (bus.in_signed) ext = '0 - psum_ext;
        end
    end

    s_acc_add #(.W(OUT_W)) u_add (
        .acc_i (acc_op),
        .ext_i (ext),
        .sum_o (acc_d)
    );

`ifdef S_SHIFT_ACC_RELU_EN
    assign result = acc_d[OUT_W-1] ? '0 : acc_d;
`else
    assign result = acc_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            // acc_out_q deliberately keeps its last value; only its valid drops.
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST_PLANE) begin
                            cnt_q       <= '0;
                            acc_out_q   <= result;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.psum_ready = (state_q != DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.acc_out    = acc_out_q;
    assign bus.out_valid  = out_valid_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_s_shift_acc.sv
// Directed and randomized bench for s_shift_acc, checked against an arithmetic bit-plane model.
// Honours S_SHIFT_ACC_RELU_EN the same way as the design.
module tb_s_shift_acc;
    import s_shift_acc_pkg::*;

    localparam int PW = 24;
    localparam int NB = 8;
    localparam int OW = PW + NB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s_shift_acc_if #(.PSUM_W(PW), .OUT_W(OW)) bus ();
    state_t state_o;

    s_shift_acc #(.PSUM_W(PW), .IN_BITS(NB), .OUT_W(OW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    int checks = 0;
    int errors = 0;
    int gap_max = 0;
    logic [PW-1:0] pl [NB];
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Dot product of the bit-planes: plane k has weight 2^(NB-1-k), negative for plane 0 when signed.
    function automatic logic [OW-1:0] model(input logic s);
        longint acc;
        longint v;
        longint w;
        acc = 0;
        for (int k = 0; k < NB; k++) begin
            v = longint'(signed'(pl[k]));
            w = longint'(1) << (NB - 1 - k);
            if (k == 0 && s) acc = acc - v * w;
            else acc = acc + v * w;
        end
`ifdef S_SHIFT_ACC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[OW-1:0];
    endfunction

    task automatic send_plane(input int k, input logic s, input logic clr);
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        chk("psum_ready_accum", bus.psum_ready, 1'b1);
        bus.psum       = pl[k];
        bus.in_signed  = (k == 0) ? s : 1'($urandom);
        bus.clear      = clr;
        bus.psum_valid = 1'b1;
        @(posedge clk); #1;
        bus.psum_valid = 1'b0;
        bus.clear      = 1'b0;
        bus.psum       = PW'($urandom);
    endtask

    task automatic run_frame(input logic s, input int hold);
        logic [OW-1:0] exp;
        exp_q.push_back(model(s));
        for (int k = 0; k < NB; k++) begin
            send_plane(k, s, 1'b0);
            if (k < NB - 1) chk("out_valid_early", bus.out_valid, 1'b0);
        end
        exp = exp_q.pop_front();
        chk("out_valid_latency", bus.out_valid, 1'b1);
        chk("acc_out", bus.acc_out, exp);
        chk("psum_ready_done", bus.psum_ready, 1'b0);
        chk("busy_done", bus.busy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_acc_out", bus.acc_out, exp);
            chk("hold_out_valid", bus.out_valid, 1'b1);
            chk("hold_psum_ready", bus.psum_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", bus.out_valid, 1'b0);
        chk("busy_idle", bus.busy, 1'b0);
        chk("psum_ready_idle", bus.psum_ready, 1'b1);
    endtask

    task automatic fill(input logic [PW-1:0] v);
        for (int k = 0; k < NB; k++) pl[k] = v;
    endtask

    initial begin
        bus.clear      = 1'b0;
        bus.in_signed  = 1'b0;
        bus.psum       = '0;
        bus.psum_valid = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset values
        #12;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_acc_out", bus.acc_out, '0);
        chk("rst_psum_ready", bus.psum_ready, 1'b1);
        chk("rst_state", state_o, IDLE);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed all-ones: -128 + 127 = -1
        fill(PW'(1));
        run_frame(1'b1, 0);
`ifdef S_SHIFT_ACC_RELU_EN
        chk("signed_ones_lit", bus.acc_out, 32'h0);
`else
        chk("signed_ones_lit", bus.acc_out, 32'hFFFF_FFFF);
`endif

        // Unsigned all-ones: 255
        run_frame(1'b0, 0);
        chk("unsigned_ones_lit", bus.acc_out, 32'd255);

        // Most negative psum on signed plane 0
        fill('0);
        pl[0] = 24'h80_0000;
        run_frame(1'b1, 0);
        chk("min_psum_lit", bus.acc_out, 32'h4000_0000);

        // Backpressure for 5 cycles, then a second frame
        fill(PW'(1));
        run_frame(1'b0, 5);
        fill(PW'(2));
        run_frame(1'b0, 0);
        chk("after_bp_lit", bus.acc_out, 32'd510);

        // Gaps between planes
        gap_max = 1;
        fill('0);
        pl[0] = PW'(3);
        pl[NB-1] = PW'(2);
        run_frame(1'b0, 1);
        chk("gaps_lit", bus.acc_out, 32'd386);
        gap_max = 0;

        // Clear together with the 4th plane accept
        held = bus.acc_out;
        fill(PW'(1));
        for (int k = 0; k < 3; k++) send_plane(k, 1'b0, 1'b0);
        send_plane(3, 1'b0, 1'b1);
        chk("clr_state", state_o, IDLE);
        chk("clr_busy", bus.busy, 1'b0);
        chk("clr_acc_out_kept", bus.acc_out, held);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("clr_out_valid", bus.out_valid, 1'b0);
        end
        run_frame(1'b0, 0);
        chk("after_clr_lit", bus.acc_out, 32'd255);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            gap_max = int'($urandom_range(0, 2));
            for (int k = 0; k < NB; k++) pl[k] = PW'($urandom);
            if (f % 4 == 0) pl[0] = 24'h80_0000;
            run_frame(1'($urandom), int'($urandom_range(0, 3)));
        end
        gap_max = 0;

        // Reset asserted mid-frame
        fill(PW'(5));
        for (int k = 0; k < 3; k++) send_plane(k, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_acc_out", bus.acc_out, '0);
        chk("midrst_state", state_o, IDLE);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        fill(PW'(1));
        run_frame(1'b0, 0);
        chk("after_rst_lit", bus.acc_out, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
